// File: rtl/if_skid_reg.sv
// Fetch-to-decode pipeline register with a valid/ready handshake and a
// 2-entry skid buffer. The head slot (H) drives decode and the skid slot (S)
// catches one extra entry when decode stalls. Because of S, in_ready only
// depends on registered state plus freeze/flush, so there is no
// combinational path from decode's out_ready back to fetch.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (acc = in_valid & in_ready, deq = out_valid & out_ready).
// Valid is never withdrawn by this block while ready is low, and ready is
// never a function of the same-side valid.
//
// Flush empties both slots, forces the head instruction to NOP and adds
// the number of discarded valid entries to a saturating drop counter.
// Freeze holds everything and masks both handshakes.
module if_skid_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000,
  parameter int                 DROP_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [1:0]         occupancy,
  output logic [DROP_W-1:0]  drop_count
);

  logic               h_valid_q, h_valid_d;
  logic [PC_W-1:0]    h_pc_q, h_pc_d;
  logic [INSTR_W-1:0] h_instr_q, h_instr_d;
  logic               s_valid_q, s_valid_d;
  logic [PC_W-1:0]    s_pc_q, s_pc_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic               acc;
  logic               deq;
  logic [1:0]         drop_inc;
  logic [DROP_W:0]    drop_sum;

  // Handshake signals and status outputs, all derived from registered state.
  always_comb begin
    in_ready        = ~s_valid_q & ~freeze & ~flush;
    out_valid       = h_valid_q & ~freeze;
    acc             = in_valid & in_ready;
    deq             = out_valid & out_ready;
    pc_out          = h_pc_q;
    instruction_out = h_instr_q;
    occupancy       = {1'b0, h_valid_q} + {1'b0, s_valid_q};
    drop_count      = drop_q;
  end

  // Next-state: flush beats freeze beats normal slot movement.
  always_comb begin
    h_valid_d = h_valid_q;
    h_pc_d    = h_pc_q;
    h_instr_d = h_instr_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_instr_d = s_instr_q;
    drop_d    = drop_q;
    drop_inc  = {1'b0, h_valid_q} + {1'b0, s_valid_q};
    drop_sum  = {1'b0, drop_q} + (DROP_W+1)'(drop_inc);

    if (flush) begin
      // Discard both slots; pc fields keep their last value.
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
      h_instr_d = NOP_INSTR;
      drop_d    = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end else if (freeze) begin
      // Hold: acc and deq are already masked low.
    end else if (!h_valid_q) begin
      if (acc) begin
        h_valid_d = 1'b1;
        h_pc_d    = pc_in;
        h_instr_d = instruction_in;
      end
    end else if (deq) begin
      if (s_valid_q) begin
        // Skid entry moves up; in_ready was low so nothing new arrives.
        h_valid_d = 1'b1;
        h_pc_d    = s_pc_q;
        h_instr_d = s_instr_q;
        s_valid_d = 1'b0;
      end else if (acc) begin
        h_valid_d = 1'b1;
        h_pc_d    = pc_in;
        h_instr_d = instruction_in;
      end else begin
        h_valid_d = 1'b0;
        h_instr_d = NOP_INSTR;
      end
    end else if (acc) begin
      // Decode stalled with the head full: park the new entry in S.
      s_valid_d = 1'b1;
      s_pc_d    = pc_in;
      s_instr_d = instruction_in;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_valid_q <= 1'b0;
      h_pc_q    <= '0;
      h_instr_q <= NOP_INSTR;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_instr_q <= NOP_INSTR;
      drop_q    <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_pc_q    <= h_pc_d;
      h_instr_q <= h_instr_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_instr_q <= s_instr_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_if_skid_reg.sv
// Bench for if_skid_reg: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_if_skid_reg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DROP_W  = 2;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  localparam logic [INSTR_W-1:0] NOP = 32'hE1A00000;

  logic               clk;
  logic               rst;
  logic               freeze;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instruction_in;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instruction_out;
  logic [1:0]         occupancy;
  logic [DROP_W-1:0]  drop_count;

  int errors = 0;
  int checks = 0;

  if_skid_reg #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instruction_out(instruction_out),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The buffer is a FIFO of at most two {pc, instr} entries. When it is
  // empty, decode sees the last pc that left the head and a NOP.
  logic [PC_W+INSTR_W-1:0] exp_q[$];
  logic [PC_W-1:0]         m_last_pc;
  int                      m_drop;
  bit                      model_ok = 0;

  always @(posedge clk) begin
    bit m_acc, m_deq;
    if (!rst) begin
      exp_q.delete();
      m_last_pc = '0;
      m_drop    = 0;
      model_ok  = 1;
    end else if (flush) begin
      if (exp_q.size() > 0) m_last_pc = exp_q[0][PC_W+INSTR_W-1:INSTR_W];
      m_drop = m_drop + exp_q.size();
      if (m_drop > DROP_MAX) m_drop = DROP_MAX;
      exp_q.delete();
    end else if (!freeze) begin
      m_deq = (exp_q.size() > 0) && out_ready;
      m_acc = in_valid && (exp_q.size() < 2);
      if (m_deq) begin
        m_last_pc = exp_q[0][PC_W+INSTR_W-1:INSTR_W];
        void'(exp_q.pop_front());
      end
      if (m_acc) exp_q.push_back({pc_in, instruction_in});
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [PC_W-1:0]    e_pc;
      logic [INSTR_W-1:0] e_ins;
      if (exp_q.size() > 0) begin
        e_pc  = exp_q[0][PC_W+INSTR_W-1:INSTR_W];
        e_ins = exp_q[0][INSTR_W-1:0];
      end else begin
        e_pc  = m_last_pc;
        e_ins = NOP;
      end
      chk("out_valid", 64'(out_valid), 64'((exp_q.size() > 0) && !freeze));
      chk("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) && !freeze && !flush));
      chk("pc_out", 64'(pc_out), 64'(e_pc));
      chk("instruction_out", 64'(instruction_out), 64'(e_ins));
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
    end
  end

  // ---------------- driver ----------------
  // Apply one cycle of inputs just after the edge, then return at the
  // following falling edge so literal checks see that cycle's outputs.
  task automatic cyc(input logic r, input logic frz, input logic fl, input logic iv,
                     input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    @(posedge clk);
    #1;
    rst = r; freeze = frz; flush = fl; in_valid = iv;
    pc_in = pc; instruction_in = ins; out_ready = ordy;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
    pc_in = '0; instruction_in = '0; out_ready = 1'b0;

    // Reset for two cycles.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst pc_out", 64'(pc_out), 64'd0);
    chk("rst instr", 64'(instruction_out), 64'hE1A00000);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst occupancy", 64'(occupancy), 64'd0);
    chk("rst drop", 64'(drop_count), 64'd0);

    // Streaming with decode always ready.
    cyc(1, 0, 0, 1, 4, 32'hA, 1);
    chk("stream first lat", 64'(out_valid), 64'd0);
    cyc(1, 0, 0, 1, 8, 32'hB, 1);
    chk("stream ov", 64'(out_valid), 64'd1);
    chk("stream pc4", 64'(pc_out), 64'd4);
    chk("stream instrA", 64'(instruction_out), 64'hA);
    chk("stream occ", 64'(occupancy), 64'd1);
    cyc(1, 0, 0, 1, 12, 32'hC, 1);
    chk("stream pc8", 64'(pc_out), 64'd8);
    chk("stream occ2", 64'(occupancy), 64'd1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("stream pc12", 64'(pc_out), 64'd12);
    chk("stream instrC", 64'(instruction_out), 64'hC);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("empty ov", 64'(out_valid), 64'd0);
    chk("empty pc", 64'(pc_out), 64'd12);
    chk("empty nop", 64'(instruction_out), 64'hE1A00000);
    chk("stream drop", 64'(drop_count), 64'd0);

    // Back-pressure into the skid slot.
    cyc(1, 0, 0, 1, 4, 32'h104, 0);
    cyc(1, 0, 0, 1, 8, 32'h108, 0);
    chk("bp occ1", 64'(occupancy), 64'd1);
    chk("bp ir1", 64'(in_ready), 64'd1);
    cyc(1, 0, 0, 1, 12, 32'h10C, 0);
    chk("bp occ2", 64'(occupancy), 64'd2);
    chk("bp ir0", 64'(in_ready), 64'd0);
    chk("bp head4", 64'(pc_out), 64'd4);
    cyc(1, 0, 0, 1, 12, 32'h10C, 0);
    chk("bp hold occ2", 64'(occupancy), 64'd2);
    cyc(1, 0, 0, 1, 12, 32'h10C, 1);
    chk("bp out4", 64'(pc_out), 64'd4);
    chk("bp ir still0", 64'(in_ready), 64'd0);
    cyc(1, 0, 0, 1, 12, 32'h10C, 1);
    chk("bp out8", 64'(pc_out), 64'd8);
    chk("bp ir back", 64'(in_ready), 64'd1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("bp out12", 64'(pc_out), 64'd12);
    chk("bp occ after", 64'(occupancy), 64'd1);
    cyc(1, 0, 0, 0, 0, 0, 1);

    // Flush with a full buffer and a simultaneous input.
    cyc(1, 0, 0, 1, 20, 32'h120, 0);
    cyc(1, 0, 0, 1, 24, 32'h124, 0);
    cyc(1, 0, 1, 1, 40, 32'h140, 0);
    chk("fl pre occ", 64'(occupancy), 64'd2);
    chk("fl ir", 64'(in_ready), 64'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("fl ov", 64'(out_valid), 64'd0);
    chk("fl nop", 64'(instruction_out), 64'hE1A00000);
    chk("fl occ", 64'(occupancy), 64'd0);
    chk("fl drop", 64'(drop_count), 64'd2);
    chk("fl pc hold", 64'(pc_out), 64'd20);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("fl no 40", 64'(out_valid), 64'd0);

    // Freeze holds a single head entry.
    cyc(1, 0, 0, 1, 16, 32'h116, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 1, 99, 32'h199, 1);
      chk("frz ov", 64'(out_valid), 64'd0);
      chk("frz ir", 64'(in_ready), 64'd0);
      chk("frz occ", 64'(occupancy), 64'd1);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("frz rel ov", 64'(out_valid), 64'd1);
    chk("frz rel pc", 64'(pc_out), 64'd16);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);

    // Drop counter saturation (DROP_W=2, so max 3).
    cyc(1, 0, 0, 1, 52, 32'h152, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("sat pre occ", 64'(occupancy), 64'd1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sat reach", 64'(drop_count), 64'd3);
    cyc(1, 0, 0, 1, 56, 32'h156, 0);
    cyc(1, 0, 0, 1, 60, 32'h160, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sat hold", 64'(drop_count), 64'd3);
    chk("sat occ", 64'(occupancy), 64'd0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sat empty fl", 64'(drop_count), 64'd3);

    // Reset beats flush and freeze.
    cyc(1, 0, 0, 1, 64, 32'h164, 0);
    cyc(0, 1, 1, 1, 68, 32'h168, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("prio ov", 64'(out_valid), 64'd0);
    chk("prio pc", 64'(pc_out), 64'd0);
    chk("prio instr", 64'(instruction_out), 64'hE1A00000);
    chk("prio ir", 64'(in_ready), 64'd1);
    chk("prio occ", 64'(occupancy), 64'd0);
    chk("prio drop", 64'(drop_count), 64'd0);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0),
          $urandom, $urandom,
          ($urandom_range(0, 2) != 0));
    end
    cyc(1, 0, 0, 0, 0, 0, 1);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
